// File: rtl/uu_rd_tracker_pkg.sv
// Shared types and default sizing for the execution-unit rd tracker
// and the raw/waw unit logic that consumes its outputs.
package uu_rd_tracker_pkg;

  localparam int NUM_RDS       = 9;
  localparam int RD_ADDR_WIDTH = 5;
  localparam int INT_UU_RDS    = 2;

  typedef enum logic [1:0] {
    UU_IDLE   = 2'd0,
    UU_BUSY   = 2'd1,
    UU_KILLED = 2'd2
  } uu_state_t;

  typedef logic [NUM_RDS-1:0] uu_mask_t;

endpackage

// File: rtl/uu_rd_entry.sv
// One tracked execution unit: pending rd, its register class and the
// IDLE/BUSY/KILLED lifecycle.
module uu_rd_entry
  import uu_rd_tracker_pkg::*;
#(
  parameter int rd_addr_width = RD_ADDR_WIDTH,
  parameter bit int_unit      = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [rd_addr_width-1:0] start_rd,
  input  logic                     start_fp,
  input  logic                     done,
  input  logic                     clear,
  output logic [rd_addr_width-1:0] rd,
  output logic                     fp,
  output uu_state_t                state,
  output logic                     wb_kill,
  output logic                     err
);

  uu_state_t                state_reg, state_next;
  logic [rd_addr_width-1:0] rd_reg, rd_next;
  logic                     fp_reg, fp_next;
  logic                     fp_eff;
  logic                     free;

  always_comb begin
    // Integer units can only ever write integer registers.
    fp_eff  = start_fp && !int_unit;
    free    = (state_reg == UU_IDLE) || done;
    wb_kill = done && ((state_reg == UU_KILLED) || (state_reg == UU_BUSY && clear));
    err     = (done && state_reg == UU_IDLE) || (start && !done && state_reg != UU_IDLE);

    state_next = state_reg;
    rd_next    = rd_reg;
    fp_next    = fp_reg;
    if (done) begin
      state_next = UU_IDLE;
    end else if (state_reg == UU_BUSY && clear) begin
      state_next = UU_KILLED;
    end
    // x0 is hardwired, so an integer write to it never needs tracking.
    if (start && free && (fp_eff || start_rd != '0)) begin
      state_next = UU_BUSY;
      rd_next    = start_rd;
      fp_next    = fp_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= UU_IDLE;
      rd_reg    <= '0;
      fp_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_reg    <= rd_next;
      fp_reg    <= fp_next;
    end
  end

  assign rd    = rd_reg;
  assign fp    = fp_reg;
  assign state = state_reg;

endmodule

// File: rtl/uu_rd_tracker.sv
// Tracks the destination register of every in-flight execution unit,
// raises RAW stalls for the ID stage and kills writebacks cleared by WAW.
module uu_rd_tracker
  import uu_rd_tracker_pkg::*;
#(
  parameter int num_rds       = NUM_RDS,
  parameter int rd_addr_width = RD_ADDR_WIDTH,
  parameter int int_uu_rds    = INT_UU_RDS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [num_rds-1:0]       unit_start,
  input  logic [rd_addr_width-1:0] start_rd,
  input  logic                     start_fp,
  input  logic [num_rds-1:0]       unit_done,
  input  logic [num_rds-1:0]       clear_rd,
  input  logic [rd_addr_width-1:0] id_rs1,
  input  logic [rd_addr_width-1:0] id_rs2,
  input  logic [rd_addr_width-1:0] id_rs3,
  input  logic                     id_rs1_fp,
  input  logic                     id_rs2_fp,
  input  logic                     id_rs3_fp,
  input  logic                     id_rs3_used,
  output logic [rd_addr_width-1:0] rd_used [num_rds],
  output logic [num_rds-1:0]       all_uu_rd_busy,
  output logic [num_rds-1:0]       unit_occupied,
  output logic [num_rds-1:0]       wb_kill,
  output logic                     raw_stall,
  output logic                     proto_err
);

  logic [num_rds-1:0] err;
  logic [num_rds-1:0] hit;
  logic               fp_flag [num_rds];
  uu_state_t          state [num_rds];
  logic               proto_err_reg;

  // Integer x0 sources never depend on anything.
  function automatic logic src_hit(input logic [rd_addr_width-1:0] rd,
                                   input logic                     fp,
                                   input logic [rd_addr_width-1:0] rs,
                                   input logic                     rs_fp);
    return (rd == rs) && (fp == rs_fp) && (rs_fp || rs != '0);
  endfunction

  generate
    for (genvar gi = 0; gi < num_rds; gi++) begin : g_entry
      uu_rd_entry #(
        .rd_addr_width(rd_addr_width),
        .int_unit     (gi < int_uu_rds)
      ) u_entry (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (unit_start[gi]),
        .start_rd(start_rd),
        .start_fp(start_fp),
        .done    (unit_done[gi]),
        .clear   (clear_rd[gi]),
        .rd      (rd_used[gi]),
        .fp      (fp_flag[gi]),
        .state   (state[gi]),
        .wb_kill (wb_kill[gi]),
        .err     (err[gi])
      );

      assign all_uu_rd_busy[gi] = (state[gi] == UU_BUSY);
      assign unit_occupied[gi]  = (state[gi] != UU_IDLE);
      assign hit[gi] = all_uu_rd_busy[gi] &&
                       (src_hit(rd_used[gi], fp_flag[gi], id_rs1, id_rs1_fp) ||
                        src_hit(rd_used[gi], fp_flag[gi], id_rs2, id_rs2_fp) ||
                        (id_rs3_used && src_hit(rd_used[gi], fp_flag[gi], id_rs3, id_rs3_fp)));
    end
  endgenerate

  assign raw_stall = |hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      proto_err_reg <= 1'b0;
    end else if (|err) begin
      proto_err_reg <= 1'b1;
    end
  end

  assign proto_err = proto_err_reg;

endmodule
